load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port in the MIPS datapath. Accepts one load/store request at a time from the CPU control path, then drives the word-organised data memory's read/write-enable interface. Sub-word stores (sb/sh) run as read-modify-write, and sub-word loads (lb/lbu/lh/lhu) are extracted and extended. Requests are checked for alignment, and a single-cycle response pulse goes back to the requester.

## Interface
- WORD_ADDR_BITS, 10: word-index width of the data memory (1024 words); higher address bits pass through unchanged.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- reqValid  in  1  request present.
- reqReady  out  1  block can accept a request; a request is accepted on the rising edge where reqValid && reqReady.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- reqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- reqAddress  in  32  byte address.
- reqData  in  32  store data; the low byte/halfword is used for sub-word stores.
- respValid  out  1  one-cycle completion pulse.
- respData  out  32  load result; 0 for stores and errors.
- respError  out  1  valid with respValid; 1 = misaligned or illegal size, no memory access made.
- memAddress  out  32  word-aligned address, {addr[31:2],2'b00}.
- memReadEnable  out  1  memory read strobe.
- memWriteEnable  out  1  memory write strobe.
- memWriteData  out  32  word to write.
- memReadData  in  32  registered memory read data. It is valid in the cycle after memReadEnable was high at a rising edge, and is 0 otherwise.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE, RESP.
- IDLE: reqReady=1. On acceptance, latch write, size, signed, address and data. Then:
  - misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size 11 → RESP with error set.
  - word store → WRITE.
  - load or sub-word store → READ.
- READ: memReadEnable=1 for exactly one cycle → CAPTURE.
- CAPTURE: sample memReadData into a holding register.
  - Load: extract lane, extend → RESP.
  - Sub-word store: merge new lane into the sampled word → WRITE.
- WRITE: memWriteEnable=1 for exactly one cycle, memWriteData = full or merged word → RESP.
- RESP: respValid=1, respData/respError driven from registers → IDLE.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], with k = addr[1:0]. Halfword lane is addr[1] (bits [15:0] or [31:16]).
- Extension: lb/lh replicate bit 7/15 into the upper bits; lbu/lhu zero-fill.
- memReadEnable and memWriteEnable are never high together, and never high for an error request.
- memAddress is held stable from READ through WRITE.
- No response backpressure: the requester must take respValid when it is pulsed.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE.
  - reqReady=0 while reset is high, 1 after release.
  - respValid=0, respData=0, respError=0.
  - memReadEnable=0, memWriteEnable=0, memAddress=0, memWriteData=0.
- Latency from the acceptance edge to the respValid cycle:
  - error: 1 cycle.
  - word store: 2 cycles.
  - load: 3 cycles.
  - sub-word store: 4 cycles.
- reqReady is low from the accept edge until the cycle after RESP, so back-to-back requests are spaced by latency+1.
- Reset mid-operation: any in-flight strobe drops immediately, the pending write is abandoned (memory unchanged), no response is issued, and the latched request is discarded.
- reqValid held high during reset is not accepted until the first rising edge after reset deasserts.

## Test plan
- Word access: store 0xDEADBEEF at 0x10, then load word from 0x10.
  - Store: memWriteEnable pulses once with memAddress 0x10; respValid 2 cycles after accept.
  - Load: respData=0xDEADBEEF, respError=0, respValid 3 cycles after accept.
- Byte access: word 0x11223344 at 0x10, then sb 0xAA to 0x11.
  - The store writes 0x1122AA44.
  - lb 0x11 returns 0xFFFFFFAA; lbu 0x11 returns 0x000000AA.
- Halfword access: sh 0x8001 to 0x12 over 0x1122AA44.
  - The store writes 0x8001AA44.
  - lh 0x12 returns 0xFFFF8001; lhu 0x12 returns 0x00008001.
- Errors: lw at 0x13, sh at 0x11, and size 11 at 0x10.
  - Each gives respValid with respError=1 and respData=0, one cycle after accept.
  - No memReadEnable or memWriteEnable pulse occurs.
- Reset during a sub-word store: assert reset during the WRITE state of an sb.
  - memWriteEnable falls in the same cycle and the memory word is unchanged.
  - No respValid is issued.
  - After release, reqReady=1 and a following lw completes correctly.
- Streaming loads: hold reqValid high with three consecutive loads (0x00, 0x04, 0x08).
  - Each is accepted only in IDLE.
  - Responses arrive in order, spaced 4 cycles apart, with correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator for the MIPS datapath: one request at a time, sub-word
// stores as read-modify-write, sub-word loads extracted and extended.
module load_store_unit #(
  parameter int unsigned WORD_ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddress,
  output logic        memReadEnable,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_LO = 2;
  localparam int unsigned IDX_HI = WORD_ADDR_BITS + 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state, state_next;

  logic              wr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        lane_q;
  logic [15:0]       data_q;

  logic              accept;
  logic              misaligned_c;
  logic              word_store_c;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] merge_c;

  // Lane select and sign/zero extension of a loaded word
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        sz,
    input logic [1:0]        lane,
    input logic              sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: load_extract = {{24{sgn & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Insert the new byte/halfword into the word read back from memory
  function automatic logic [DATA_W-1:0] store_merge(
    input logic [DATA_W-1:0] w,
    input logic [1:0]        sz,
    input logic [1:0]        lane,
    input logic [15:0]       d
  );
    logic [DATA_W-1:0] r;
    r = w;
    if (sz == SZ_BYTE) r[{lane, 3'b000} +: 8] = d[7:0];
    else               r[{lane[1], 4'b0000} +: 16] = d;
    store_merge = r;
  endfunction

  assign misaligned_c = (reqSize == 2'b11) ||
                        ((reqSize == SZ_HALF) && reqAddress[0]) ||
                        ((reqSize == SZ_WORD) && (reqAddress[1:0] != 2'b00));
  assign word_store_c = reqWrite && (reqSize == SZ_WORD);
  assign load_c       = load_extract(memReadData, size_q, lane_q, sgn_q);
  assign merge_c      = store_merge(memReadData, size_q, lane_q, data_q);

  // Ready must rise as soon as reset releases, so it follows the state directly
  assign reqReady = (state == IDLE) && !reset;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (reqValid) begin
          accept = 1'b1;
          if (misaligned_c)      state_next = RESP;
          else if (word_store_c) state_next = WRITE;
          else                   state_next = READ;
        end
      end
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = wr_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and response are registered from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      memReadEnable  <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
      respValid      <= 1'b0;
      respError      <= 1'b0;
      respData       <= '0;
      wr_q           <= 1'b0;
      size_q         <= 2'b00;
      sgn_q          <= 1'b0;
      lane_q         <= 2'b00;
      data_q         <= '0;
    end else begin
      state          <= state_next;
      memReadEnable  <= (state_next == READ);
      memWriteEnable <= (state_next == WRITE);
      respValid      <= (state_next == RESP);
      respError      <= accept && misaligned_c;
      respData       <= ((state == CAPTURE) && !wr_q) ? load_c : '0;
      if (accept) begin
        wr_q   <= reqWrite;
        size_q <= reqSize;
        sgn_q  <= reqSigned;
        lane_q <= reqAddress[1:0];
        data_q <= reqData[15:0];
        if (!misaligned_c) begin
          memAddress <= {reqAddress[31:IDX_HI+1], reqAddress[IDX_HI:IDX_LO], 2'b00};
          if (word_store_c) memWriteData <= reqData;
        end
      end
      if ((state == CAPTURE) && wr_q) memWriteData <= merge_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read word memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqSigned = 1'b0;
  logic [31:0] reqAddress = '0;
  logic [31:0] reqData = '0;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic [31:0] memAddress;
  logic        memReadEnable;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;

  logic [31:0] mem [0:1023];
  int ren_cnt = 0;
  int wen_cnt = 0;
  int resp_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] last_waddr = '0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.WORD_ADDR_BITS(10)) dut (
    .clock(clock), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddress(reqAddress),
    .reqData(reqData), .respValid(respValid), .respData(respData),
    .respError(respError), .memAddress(memAddress),
    .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  // Word memory: read data is registered, zero when no read was strobed
  always @(posedge clock) begin
    if (memWriteEnable) begin
      mem[memAddress[11:2]] <= memWriteData;
      last_waddr <= memAddress;
    end
    memReadData <= memReadEnable ? mem[memAddress[11:2]] : 32'h0;
    ren_cnt     <= ren_cnt + (memReadEnable ? 1 : 0);
    wen_cnt     <= wen_cnt + (memWriteEnable ? 1 : 0);
    resp_cnt    <= resp_cnt + (respValid ? 1 : 0);
    overlap_cnt <= overlap_cnt + ((memReadEnable && memWriteEnable) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er,
                      output int dren, output int dwen);
    int r0, w0, g;
    @(negedge clock);
    r0 = ren_cnt;
    w0 = wen_cnt;
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
    reqAddress = a; reqData = d;
    g = 0;
    while (!reqReady && g < 20) begin
      @(negedge clock);
      g++;
    end
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    lat = -1; rd = '0; er = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (respValid) begin
        lat = n; rd = respData; er = respError;
        break;
      end
      @(negedge clock);
    end
    dren = ren_cnt - r0;
    dwen = wen_cnt - w0;
  endtask

  initial begin
    int lat, dr, dw, w0, rc0, g;
    logic [31:0] rd;
    logic er;
    int nacc, nresp;
    int acc_t [3];
    int resp_t [3];
    logic [31:0] sdat [3];
    logic pending;

    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_reqReady", 32'(reqReady), 32'd0);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_respData", respData, 32'h0);
    chk("rst_respError", 32'(respError), 32'd0);
    chk("rst_ren", 32'(memReadEnable), 32'd0);
    chk("rst_wen", 32'(memWriteEnable), 32'd0);
    chk("rst_memAddress", memAddress, 32'h0);
    chk("rst_memWriteData", memWriteData, 32'h0);
    reset = 1'b0;
    #1 chk("rel_reqReady", 32'(reqReady), 32'd1);

    // Word store then load
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, dr, dw);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_wen_pulses", 32'(dw), 32'd1);
    chk("sw_ren_pulses", 32'(dr), 32'd0);
    chk("sw_waddr", last_waddr, 32'h10);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    chk("sw_resp", {rd[30:0], er}, 32'h0);
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, dr, dw);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);

    // Byte store and loads
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, er, dr, dw);
    xfer(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, lat, rd, er, dr, dw);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_mem", mem[4], 32'h1122AA44);
    chk("sb_pulses", 32'(dr * 16 + dw), 32'h11);
    xfer(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, dr, dw);
    chk("lb_data", rd, 32'hFFFFFFAA);
    xfer(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er, dr, dw);
    chk("lbu_data", rd, 32'h000000AA);

    // Halfword store and loads
    xfer(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, lat, rd, er, dr, dw);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_mem", mem[4], 32'h8001AA44);
    xfer(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, dr, dw);
    chk("lh_data", rd, 32'hFFFF8001);
    xfer(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, dr, dw);
    chk("lhu_data", rd, 32'h00008001);
    chk("lhu_lat", 32'(lat), 32'd3);

    // Error requests
    xfer(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rd, er, dr, dw);
    chk("err_lw_lat", 32'(lat), 32'd1);
    chk("err_lw_resp", {rd[30:0], er}, 32'h1);
    chk("err_lw_strobes", 32'(dr + dw), 32'd0);
    xfer(1'b1, 2'b01, 1'b0, 32'h11, 32'h00001234, lat, rd, er, dr, dw);
    chk("err_sh_lat", 32'(lat), 32'd1);
    chk("err_sh_resp", {rd[30:0], er}, 32'h1);
    chk("err_sh_strobes", 32'(dr + dw), 32'd0);
    xfer(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, dr, dw);
    chk("err_sz_lat", 32'(lat), 32'd1);
    chk("err_sz_resp", {rd[30:0], er}, 32'h1);
    chk("err_sz_strobes", 32'(dr + dw), 32'd0);
    chk("err_mem_kept", mem[4], 32'h8001AA44);

    // Reset while an sb sits in WRITE
    xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, dr, dw);
    @(negedge clock);
    g = 0;
    while (!reqReady && g < 20) begin
      @(negedge clock);
      g++;
    end
    w0 = wen_cnt;
    rc0 = resp_cnt;
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b00; reqAddress = 32'h21; reqData = 32'h55;
    @(posedge clock);
    @(negedge clock);
    reqValid = 1'b0;
    repeat (2) @(negedge clock);
    chk("rmw_wen_before_reset", 32'(memWriteEnable), 32'd1);
    reset = 1'b1;
    #1 chk("rmw_wen_dropped", 32'(memWriteEnable), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1 chk("rmw_ready_after", 32'(reqReady), 32'd1);
    chk("rmw_mem_kept", mem[8], 32'h11223344);
    chk("rmw_no_write", 32'(wen_cnt - w0), 32'd0);
    repeat (3) @(negedge clock);
    chk("rmw_no_resp", 32'(resp_cnt - rc0), 32'd0);
    xfer(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er, dr, dw);
    chk("rmw_lw_lat", 32'(lat), 32'd3);
    chk("rmw_lw_data", rd, 32'h11223344);

    // Streaming loads with reqValid held high
    xfer(1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE0000, lat, rd, er, dr, dw);
    xfer(1'b1, 2'b10, 1'b0, 32'h04, 32'h0000BABE, lat, rd, er, dr, dw);
    xfer(1'b1, 2'b10, 1'b0, 32'h08, 32'h13572468, lat, rd, er, dr, dw);
    @(negedge clock);
    nacc = 0; nresp = 0; pending = 1'b0;
    for (int k = 0; k < 3; k++) begin
      acc_t[k] = -100; resp_t[k] = -200; sdat[k] = '0;
    end
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0; reqAddress = 32'h0;
    for (int c = 0; c < 30; c++) begin
      if (respValid) begin
        if (nresp < 3) begin
          resp_t[nresp] = c;
          sdat[nresp] = respData;
        end
        nresp++;
      end
      if (reqValid && reqReady) begin
        if (nacc < 3) acc_t[nacc] = c;
        nacc++;
        pending = 1'b1;
      end
      @(negedge clock);
      if (pending) begin
        pending = 1'b0;
        if (nacc < 3) reqAddress = 32'(nacc * 4);
        else reqValid = 1'b0;
      end
    end
    chk("stream_accepts", 32'(nacc), 32'd3);
    chk("stream_resps", 32'(nresp), 32'd3);
    chk("stream_acc_gap1", 32'(acc_t[1] - acc_t[0]), 32'd4);
    chk("stream_acc_gap2", 32'(acc_t[2] - acc_t[1]), 32'd4);
    chk("stream_resp_gap1", 32'(resp_t[1] - resp_t[0]), 32'd4);
    chk("stream_resp_gap2", 32'(resp_t[2] - resp_t[1]), 32'd4);
    chk("stream_lat0", 32'(resp_t[0] - acc_t[0]), 32'd3);
    chk("stream_data0", sdat[0], 32'hCAFE0000);
    chk("stream_data1", sdat[1], 32'h0000BABE);
    chk("stream_data2", sdat[2], 32'h13572468);

    chk("strobe_overlap", 32'(overlap_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
